gfx256_wbm_read_arbiter: RTL and testbench

Read-side responder for the pixel pipeline. It accepts single-word read requests from up to NCLIENT clients (blender target read, texture reader, z-buffer reader), arbitrates round-robin, and runs one Wishbone classic read cycle per grant on the 256-bit memory bus. It returns the data word with a one-cycle ack to the granted client. It drives the shared busy flag that clients sample before raising a request.

---
 rtl/gfx256_pkg.sv | 13 +
 rtl/gfx256_rr_pick.sv | 26 ++
 rtl/gfx256_wbm_read_arbiter.sv | 121 ++++++++++++
 tb/tb_gfx256_wbm_read_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 memory read arbiter.
package gfx256_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS,
    ARB_GAP
  } arb_state_e;

  // Replicated to DW/8 bits for the idle/reset value of the bus byte selects.
  localparam logic SEL_DEFAULT_BIT = 1'b1;

endpackage

// File: rtl/gfx256_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module gfx256_rr_pick
  import gfx256_pkg::*;
#(
  parameter int NCLIENT = 3,
  localparam int GW = $clog2(NCLIENT)
) (
  input  logic [NCLIENT-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               valid
);

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = NCLIENT; off >= 1; off--) begin
      if (req[(int'(last_grant) + off) % NCLIENT]) begin
        grant = GW'((int'(last_grant) + off) % NCLIENT);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx256_wbm_read_arbiter.sv
// Round-robin read arbiter: one Wishbone classic read per grant, one-cycle ack back to the client.
module gfx256_wbm_read_arbiter
  import gfx256_pkg::*;
#(
  parameter int NCLIENT = 3,
  parameter int AW      = 32,
  parameter int DW      = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NCLIENT-1:0]      req_i,
  input  logic [NCLIENT*AW-1:0]   addr_i,
  input  logic [NCLIENT*DW/8-1:0] sel_i,
  output logic [NCLIENT-1:0]      ack_o,
  output logic [DW-1:0]           dat_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [AW-1:0]           wb_adr_o,
  output logic [DW/8-1:0]         wb_sel_o,
  input  logic [DW-1:0]           wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SW = DW / 8;
  localparam int GW = $clog2(NCLIENT);
  localparam logic [GW-1:0] LAST_RST = GW'(NCLIENT - 1);

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic               cyc_q, cyc_d;
  logic [NCLIENT-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic [GW-1:0]      pick;
  logic               pick_valid;

  gfx256_rr_pick #(.NCLIENT(NCLIENT)) u_pick (
    .req        (req_i),
    .last_grant (last_q),
    .grant      (pick),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      adr_q   <= '0;
      sel_q   <= {SW{SEL_DEFAULT_BIT}};
      cyc_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    ack_d   = '0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          adr_d   = addr_i[int'(pick)*AW +: AW];
          sel_d   = sel_i[int'(pick)*SW +: SW];
          cyc_d   = 1'b1;
          state_d = ARB_BUS;
        end
      end
      ARB_BUS: begin
        // A started cycle always finishes, even if the requester withdrew.
        if (wb_ack_i || wb_err_i) begin
          cyc_d          = 1'b0;
          dat_d          = wb_err_i ? '0 : wb_dat_i;
          ack_d[grant_q] = 1'b1;
          err_d          = wb_err_i;
          last_d         = grant_q;
          state_d        = ARB_GAP;
        end
      end
      ARB_GAP: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy_o   = (state_q != ARB_IDLE);
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign dat_o    = dat_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_gfx256_wbm_read_arbiter.sv
// Randomised bench for the read arbiter against a transaction-level round-robin model.
module tb_gfx256_wbm_read_arbiter;

  localparam int NC = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int SW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NC-1:0]     req;
  logic [NC*AW-1:0]  addr_i;
  logic [NC*SW-1:0]  sel_i;
  logic [NC-1:0]     ack_o;
  logic [DW-1:0]     dat_o;
  logic              err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]     wb_adr_o;
  logic [SW-1:0]     wb_sel_o;
  logic [DW-1:0]     wb_dat_i;
  logic              wb_ack_i, wb_err_i;

  logic [AW-1:0]     caddr [NC];
  logic [SW-1:0]     csel  [NC];

  gfx256_wbm_read_arbiter #(.NCLIENT(NC), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req), .addr_i(addr_i), .sel_i(sel_i),
    .ack_o(ack_o), .dat_o(dat_o), .err_o(err_o), .busy_o(busy_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    addr_i = '0;
    sel_i  = '0;
    for (int c = 0; c < NC; c++) begin
      addr_i[c*AW +: AW] = caddr[c];
      sel_i[c*SW +: SW]  = csel[c];
    end
  end

  int n_vec = 0;
  int n_mis = 0;

  // Model: m_phase 0 = no transaction, 1 = bus cycle open, 2 = one cycle after completion.
  int            m_phase, ptr, m_win, wait_cnt;
  bit            cur_err, auto_mode, force_dat;
  int            force_lat, force_err;
  logic          exp_cyc, exp_err, exp_busy;
  logic [NC-1:0] exp_ack;
  logic [AW-1:0] exp_adr;
  logic [SW-1:0] exp_sel;
  logic [DW-1:0] exp_dat;
  int            glog[$];

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr(int p, logic [NC-1:0] r);
    for (int d = 1; d <= NC; d++)
      if (r[(p + d) % NC]) return (p + d) % NC;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_phase = 0; ptr = NC - 1; m_win = 0; wait_cnt = 0; cur_err = 0;
    exp_cyc = 0; exp_err = 0; exp_busy = 0; exp_ack = '0;
    exp_adr = '0; exp_sel = '1; exp_dat = '0;
  endtask

  task automatic sample_and_check();
    @(negedge clk_i);
    chk("cyc", wb_cyc_o, exp_cyc);
    chk("stb", wb_stb_o, exp_cyc);
    chk("busy", busy_o, exp_busy);
    chk("ack", ack_o, exp_ack);
    chk("err", err_o, exp_err);
    if (exp_cyc) begin
      chk("adr", wb_adr_o, exp_adr);
      chk("sel", wb_sel_o, exp_sel);
    end
    if (exp_ack != '0) begin
      chk("dat", dat_o, exp_dat);
      glog.push_back(m_win);
    end
    for (int c = 0; c < NC; c++)
      if (exp_ack[c]) req[c] = 1'b0;
    if (auto_mode) begin
      for (int c = 0; c < NC; c++) begin
        if (!req[c] && !exp_busy && ($urandom % 3 == 0)) begin
          req[c]   = 1'b1;
          caddr[c] = $urandom;
          csel[c]  = $urandom;
        end
      end
      if (m_phase == 1 && req[m_win] && ($urandom % 10 == 0)) req[m_win] = 1'b0;
    end
  endtask

  task automatic drive_and_model();
    bit fin = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = force_dat ? {SW{8'hA5}} : rnd_word();
    if (m_phase == 1) begin
      if (wait_cnt == 0) begin
        if (cur_err) begin
          wb_err_i = 1'b1;
          wb_ack_i = 1'($urandom % 2);
        end else begin
          wb_ack_i = 1'b1;
        end
        fin = 1;
      end else begin
        wait_cnt--;
      end
    end
    exp_ack = '0;
    exp_err = 1'b0;
    case (m_phase)
      0: if (req != '0) begin
        m_win    = rr(ptr, req);
        exp_adr  = caddr[m_win];
        exp_sel  = csel[m_win];
        exp_cyc  = 1'b1;
        m_phase  = 1;
        wait_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        cur_err  = (force_err >= 0) ? bit'(force_err) : ($urandom % 6 == 0);
      end
      1: if (fin) begin
        exp_cyc = 1'b0;
        exp_ack = NC'(1) << m_win;
        exp_err = cur_err;
        exp_dat = cur_err ? '0 : wb_dat_i;
        ptr     = m_win;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    exp_busy = (m_phase != 0);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((m_phase != 0 || req != '0) && n < budget) begin
      sample_and_check();
      drive_and_model();
      n++;
    end
    chk("drain_idle", (m_phase != 0) || (req != '0), 1'b0);
  endtask

  task automatic check_order(string tag, int exp_q[$]);
    chk({tag, "_count"}, glog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < glog.size()) ? glog[i] : -1, exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dropped;
    int n;
    rst_i = 1'b1; req = '0; wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0;
    for (int c = 0; c < NC; c++) begin caddr[c] = '0; csel[c] = '0; end
    auto_mode = 0; force_dat = 0; force_lat = -1; force_err = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_ack", ack_o, '0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_dat", dat_o, '0);
    chk("rst_adr", wb_adr_o, '0);
    chk("rst_sel", wb_sel_o, {SW{1'b1}});
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    rst_i = 1'b0;
    drive_and_model();

    // all three request together, twice
    for (int round = 0; round < 2; round++) begin
      glog.delete();
      sample_and_check();
      req = '1;
      for (int c = 0; c < NC; c++) begin caddr[c] = $urandom; csel[c] = $urandom; end
      drive_and_model();
      drain(80);
      check_order("rr_order", '{0, 1, 2});
    end

    // single read from client 0 with a two-cycle memory latency
    glog.delete();
    force_lat = 1; force_dat = 1;
    sample_and_check();
    req[0] = 1'b1; caddr[0] = 32'h0000_1000; csel[0] = '1;
    drive_and_model();
    drain(20);
    check_order("single", '{0});
    chk("single_dat", dat_o, {SW{8'hA5}});
    force_dat = 0; force_lat = -1;

    // error termination on client 2
    glog.delete();
    force_err = 1;
    sample_and_check();
    req[2] = 1'b1; caddr[2] = $urandom; csel[2] = $urandom;
    drive_and_model();
    drain(20);
    check_order("err_client", '{2});
    chk("err_dat", dat_o, '0);
    force_err = 0;

    // client 1 withdraws during the bus cycle, client 0 raises meanwhile
    glog.delete();
    force_lat = 3;
    sample_and_check();
    req[1] = 1'b1; caddr[1] = $urandom; csel[1] = $urandom;
    drive_and_model();
    dropped = 0; n = 0;
    while (!dropped && n < 10) begin
      sample_and_check();
      if (m_phase == 1) begin
        req[1] = 1'b0;
        req[0] = 1'b1; caddr[0] = $urandom; csel[0] = $urandom;
        dropped = 1;
      end
      drive_and_model();
      n++;
    end
    drain(40);
    check_order("withdraw", '{1, 0});
    force_lat = -1;

    // reset in the middle of a bus cycle
    force_lat = 20;
    sample_and_check();
    req[0] = 1'b1; caddr[0] = $urandom; csel[0] = $urandom;
    drive_and_model();
    sample_and_check();
    drive_and_model();
    sample_and_check();
    rst_i = 1'b1; req = '0; wb_ack_i = 0; wb_err_i = 0;
    #1;
    chk("rst_mid_cyc", wb_cyc_o, 1'b0);
    chk("rst_mid_stb", wb_stb_o, 1'b0);
    chk("rst_mid_busy", busy_o, 1'b0);
    model_reset();
    @(negedge clk_i);
    chk("rst_mid_ack", ack_o, '0);
    chk("rst_mid_dat", dat_o, '0);
    rst_i = 1'b0;
    glog.delete();
    force_lat = -1;
    req[1] = 1'b1; caddr[1] = $urandom; csel[1] = $urandom;
    drive_and_model();
    drain(20);
    check_order("after_rst", '{1});

    // randomised traffic
    force_err = -1;
    auto_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      sample_and_check();
      drive_and_model();
    end
    auto_mode = 0;
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
